serial_bit_feeder: RTL and testbench

- Parallel-in/serial-out stage directly upstream of the 10110 Moore sequence detector.
- Accepts a WIDTH-bit word over a valid/ready handshake and presents it one bit per clock, MSB first, on the detector's serial input j.
- Provides j_valid, busy and a last-bit done pulse so a controller can pace frames.

---
 rtl/serial_bit_feeder_pkg.sv | 14 +
 rtl/serial_bit_feeder_shift_core.sv | 41 ++++
 rtl/serial_bit_feeder.sv | 121 ++++++++++++
 tb/tb_serial_bit_feeder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the serial bit feeder: FSM state encoding,
// default parameter values and the 10110 pattern the detector looks for.
package serial_bit_feeder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } feeder_state_t;

  localparam int         DEF_WIDTH     = 8;
  localparam logic       DEF_IDLE_BIT  = 1'b0;
  localparam logic [4:0] PATTERN_10110 = 5'b10110;

endpackage

// File: rtl/serial_bit_feeder_shift_core.sv
// Shift core for the serial bit feeder: holds the word being serialised,
// counts the bits still to go and flags when the last bit is on the MSB.
module ser_shift_core
  import serial_bit_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             msb,
  output logic             last
);

  // Counter only needs to reach WIDTH-1; WIDTH >= 2 keeps this at least 1 bit.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  // Load a fresh word (priority) or shift left with zero fill while bits remain;
  // the counter stops at zero so it can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= load_data;
      cnt   <= CW'(WIDTH - 1);
    end else if (shift_en && (cnt != '0)) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      cnt   <= cnt - 1'b1;
    end
  end

  assign msb  = shreg[WIDTH-1];
  assign last = (cnt == '0);

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-in / serial-out feeder for the 10110 sequence detector.
// Takes a WIDTH-bit word over valid/ready and drives it MSB first on j,
// one bit per clock, with j_valid/busy/done for frame pacing.
// Optional build macro SER_FEEDER_SKID_EN adds a one-word holding register
// so consecutive words stream with no idle gap.
module serial_bit_feeder
  import serial_bit_feeder_pkg::*;
#(
  parameter int   WIDTH    = DEF_WIDTH,
  parameter logic IDLE_BIT = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             j,
  output logic             j_valid,
  output logic             busy,
  output logic             done
);

  feeder_state_t    state;
  logic             accept;
  logic             load;
  logic             reload;
  logic             shift_msb;
  logic             last;
  logic [WIDTH-1:0] load_data;

`ifdef SER_FEEDER_SKID_EN
  logic             full;
  logic [WIDTH-1:0] hold;

  // Ready whenever idle, or while shifting if the holder has room; on the
  // last-bit edge a held word (or a bypassing new word) reloads the core.
  always_comb begin
    din_ready = (state == ST_IDLE) || !full;
    reload    = 1'b0;
    load_data = din;
    if (state == ST_SHIFT) begin
      reload = last && (full || accept);
      if (full) begin
        load_data = hold;
      end
    end
  end

  // Park a word accepted mid-shift; release the holder when it reloads the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      hold <= '0;
    end else if (state == ST_SHIFT) begin
      if (last) begin
        if (full) begin
          full <= 1'b0;
        end
      end else if (accept) begin
        hold <= din;
        full <= 1'b1;
      end
    end
  end
`else
  // Without a holder the feeder only takes words while idle.
  always_comb begin
    din_ready = (state == ST_IDLE);
    reload    = 1'b0;
    load_data = din;
  end
`endif

  assign accept = din_valid && din_ready;
  assign load   = ((state == ST_IDLE) && accept) || reload;

  // Control FSM: leave IDLE on accept, return once the last bit has been
  // shown and nothing follows; busy is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_SHIFT;
            busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (last && !reload) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  ser_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(load_data),
    .shift_en (state == ST_SHIFT),
    .msb      (shift_msb),
    .last     (last)
  );

  assign j_valid = busy;
  assign j       = busy ? shift_msb : IDLE_BIT;
  assign done    = busy && last;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Self-checking bench for serial_bit_feeder: an 8-bit default instance fed
// through an expected-bit queue, plus a 5-bit instance idling high.
module tb_serial_bit_feeder;
  import serial_bit_feeder_pkg::*;

  localparam int W8 = DEF_WIDTH;
  localparam int W5 = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W8-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready, j, j_valid, busy, done;

  logic [W5-1:0] din5 = '0;
  logic          din_valid5 = 1'b0;
  logic          din_ready5, j5, j_valid5, busy5, done5;

  int checks = 0;
  int fails  = 0;

  // Each entry is {expected j, expected done} for one data bit.
  logic [1:0] sb[$];

  serial_bit_feeder #(.WIDTH(W8), .IDLE_BIT(1'b0)) dut8 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .j(j), .j_valid(j_valid), .busy(busy), .done(done)
  );

  serial_bit_feeder #(.WIDTH(W5), .IDLE_BIT(1'b1)) dut5 (
    .clk(clk), .rst(rst), .din(din5), .din_valid(din_valid5), .din_ready(din_ready5),
    .j(j5), .j_valid(j_valid5), .busy(busy5), .done(done5)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every data bit on j must match the head of the queue.
  always @(negedge clk) begin
    logic [1:0] exp;
    if (!rst) begin
      if (j_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL sb_unexpected_bit: got j=%b done=%b, required no data bit", j, done);
        end else begin
          exp = sb.pop_front();
          if ({j, done} !== exp) begin
            fails++;
            $display("[TB] FAIL sb_bit: got j=%b done=%b, required j=%b done=%b", j, done, exp[1], exp[0]);
          end
        end
      end else if (done !== 1'b0) begin
        checks++;
        fails++;
        $display("[TB] FAIL sb_done_idle: got done=%b, required 0 while j_valid=0", done);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_word(input logic [W8-1:0] w);
    for (int i = W8 - 1; i >= 0; i--) begin
      sb.push_back({w[i], 1'(i == 0)});
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    din       = 8'hB0;
    din_valid = 1'b1;
    din5      = 5'b10110;
    din_valid5 = 1'b1;
    rst       = 1'b1;
    #1;
    checks++;
    if ({j, j_valid, busy, done, din_ready} !== 5'b00001) begin
      fails++;
      $display("[TB] FAIL reset_w8: got j/jv/busy/done/rdy=%b, required 00001", {j, j_valid, busy, done, din_ready});
    end
    checks++;
    if ({j5, j_valid5, busy5, done5, din_ready5} !== 5'b10001) begin
      fails++;
      $display("[TB] FAIL reset_w5: got j/jv/busy/done/rdy=%b, required 10001", {j5, j_valid5, busy5, done5, din_ready5});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({j_valid, busy, j_valid5, busy5} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_valid_ignored: got jv/busy/jv5/busy5=%b, required 0000", {j_valid, busy, j_valid5, busy5});
    end
    din_valid  = 1'b0;
    din_valid5 = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    checks++;
    if ({j_valid, din_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL reset_release: got jv/rdy=%b, required 01", {j_valid, din_ready});
    end
  endtask

  task automatic test_single();
    push_word(8'hB0);
    din       = 8'hB0;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < W8; i++) begin
      checks++;
      if ({j_valid, busy} !== 2'b11) begin
        fails++;
        $display("[TB] FAIL single_busy bit %0d: got jv/busy=%b, required 11", i, {j_valid, busy});
      end
      @(negedge clk);
    end
    checks++;
    if ({j, j_valid, busy, din_ready, sb.size() == 0} !== 5'b00011) begin
      fails++;
      $display("[TB] FAIL single_end: got j/jv/busy/rdy/drained=%b, required 00011",
               {j, j_valid, busy, din_ready, sb.size() == 0});
    end
  endtask

  task automatic test_back_to_back();
    logic [W8-1:0] words[2];
    int            acc[2];
    int            idx;
    int            ones;
    logic          jv_hist[40];
    words[0] = 8'hB0;
    words[1] = 8'h5A;
    idx      = 0;
    acc[0]   = -1;
    acc[1]   = -1;
    push_word(words[0]);
    push_word(words[1]);
    din       = words[0];
    din_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (din_valid && din_ready) begin
        acc[idx] = c;
        idx++;
      end
      @(negedge clk);
      if (idx >= 2) din_valid = 1'b0;
      else din = words[idx];
      jv_hist[c] = j_valid;
    end
    din_valid = 1'b0;
    ones = 0;
    for (int c = 0; c < 16; c++) ones += int'(jv_hist[c]);
`ifdef SER_FEEDER_SKID_EN
    checks++;
    if (acc[1] - acc[0] !== 1) begin
      fails++;
      $display("[TB] FAIL b2b_accept_gap: got %0d, required 1", acc[1] - acc[0]);
    end
    checks++;
    if (ones !== 16 || jv_hist[16] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_contiguous: got %0d valid of 16 (next=%b), required 16 (next=0)", ones, jv_hist[16]);
    end
`else
    checks++;
    if (acc[1] - acc[0] !== 9) begin
      fails++;
      $display("[TB] FAIL b2b_accept_gap: got %0d, required 9", acc[1] - acc[0]);
    end
    checks++;
    if (ones !== 15 || jv_hist[8] !== 1'b0 || jv_hist[16] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_idle_gap: got %0d valid of 16 gap=%b, required 15 gap=0", ones, jv_hist[8]);
    end
`endif
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL b2b_drain: got %0d bits left, required 0", sb.size());
    end
  endtask

  task automatic test_busy_ignore();
    push_word(8'hB0);
    din       = 8'hB0;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < W8; i++) begin
      if (i == 2) begin
        din       = 8'hFF;
        din_valid = 1'b1;
        checks++;
        if (din_ready !== 1'b0) begin
          fails++;
          $display("[TB] FAIL busy_ready: got din_ready=%b, required 0", din_ready);
        end
      end else begin
        din_valid = 1'b0;
      end
      @(negedge clk);
    end
    din_valid = 1'b0;
    checks++;
    if ({j_valid, busy, din_ready} !== 3'b001) begin
      fails++;
      $display("[TB] FAIL busy_return_idle: got jv/busy/rdy=%b, required 001", {j_valid, busy, din_ready});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0 || j_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL busy_no_extra: got left=%0d jv=%b, required 0 and 0", sb.size(), j_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    push_word(8'hB6);
    din       = 8'hB6;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    checks++;
    if ({j, j_valid, busy, done, din_ready} !== 5'b00001) begin
      fails++;
      $display("[TB] FAIL midrst_outputs: got j/jv/busy/done/rdy=%b, required 00001", {j, j_valid, busy, done, din_ready});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push_word(8'h16);
    din       = 8'h16;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if ({j, j_valid} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL midrst_new_msb: got j/jv=%b, required 01", {j, j_valid});
    end
    for (int n = 0; n < 30 && sb.size() != 0; n++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL midrst_drain: got %0d bits left, required 0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_width5();
    logic [W5-1:0] pat;
    pat        = PATTERN_10110;
    din5       = pat;
    din_valid5 = 1'b1;
    @(negedge clk);
    din_valid5 = 1'b0;
    for (int i = 0; i < W5; i++) begin
      checks++;
      if ({j5, j_valid5, done5} !== {pat[W5-1-i], 1'b1, 1'(i == W5 - 1)}) begin
        fails++;
        $display("[TB] FAIL w5_bit %0d: got j/jv/done=%b, required %b", i, {j5, j_valid5, done5},
                 {pat[W5-1-i], 1'b1, 1'(i == W5 - 1)});
      end
      @(negedge clk);
    end
    checks++;
    if ({j5, j_valid5, busy5, done5} !== 4'b1000) begin
      fails++;
      $display("[TB] FAIL w5_idle: got j/jv/busy/done=%b, required 1000", {j5, j_valid5, busy5, done5});
    end
  endtask

  initial begin
    $display("[TB] serial_bit_feeder bench start");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    repeat (2) @(negedge clk);
`ifndef SER_FEEDER_SKID_EN
    test_busy_ignore();
`endif
    test_reset_mid_shift();
    test_width5();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
